rtermcal_ctrl: RTL and testbench
================================

RTERMCAL_CTRL -- requirements
Module: rtermcal_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 16 (range 2..255), wait cycles per trial code before sampling the comparator.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on RESULT_I; SETTLE_CYC SHALL be at least SYNC_STAGES+1.
REQ-003 CLK_I  input  1  sole clock.
REQ-004 RST_I  input  1  asynchronous, active-high reset.
REQ-005 START_I  input  1  calibration request, sampled only in IDLE.
REQ-006 RESULT_I  input  2  comparator outputs from the RTERMCAL cell, asynchronous: [0] SGIO, [1] LVDS.
REQ-007 MODE_O  output  2  cell mode: 00 off, 01 SGIO compare, 10 LVDS compare.
REQ-008 D_IOSG_O  output  15 [15:1]  thermometer trim to cell and SGIO drivers.
REQ-009 D_LVDS_O  output  4  binary trim to cell and LVDS drivers.
REQ-010 BUSY_O  output  1  calibration in progress.
REQ-011 DONE_O  output  1  one-cycle completion pulse.
REQ-012 ERR_O  output  2  sticky range flags: [0] SGIO, [1] LVDS.

Function
REQ-013 RESULT_I SHALL pass through a SYNC_STAGES flop chain; only the synchronized value is evaluated.
REQ-014 States SHALL be IDLE, SG_WAIT, SG_EVAL, LV_WAIT, LV_EVAL, DONE.
REQ-015 IDLE + START_I=1 -> SG_WAIT with count n=0, D_IOSG_O=0, MODE_O=01, BUSY_O=1, ERR_O cleared; START_I ignored in all other states.
REQ-016 Each WAIT state SHALL last exactly SETTLE_CYC cycles, then one EVAL cycle; one trial = SETTLE_CYC+1 cycles.
REQ-017 D_IOSG_O SHALL be the thermometer of n: bits 1..n set, others clear.
REQ-018 SG_EVAL, sync RESULT[0]=0 and n<15: n increments, -> SG_WAIT.
REQ-019 SG_EVAL, sync RESULT[0]=1: final SGIO code = n-1, or 0 with ERR_O[0]=1 when n=0; -> LV_WAIT.
REQ-020 SG_EVAL, sync RESULT[0]=0 and n=15: final code = 15, ERR_O[0]=1; -> LV_WAIT.
REQ-021 Entering LV_WAIT: D_IOSG_O SHALL hold the final SGIO thermometer, MODE_O=10, SAR bit b=3, trial D_LVDS_O=4'b1000.
REQ-022 LV_EVAL SHALL clear trial bit b when sync RESULT[1]=1 and keep it when 0; if b>0, set bit b-1 and -> LV_WAIT; else -> DONE.
REQ-023 Final LVDS code SHALL be the largest code with RESULT[1]=0; ERR_O[1]=1 when the final code is 0 or 15.
REQ-024 DONE SHALL last one cycle: DONE_O=1, BUSY_O=0, MODE_O=00; then -> IDLE.
REQ-025 After DONE, D_IOSG_O, D_LVDS_O and ERR_O SHALL hold until the next START_I or reset.
REQ-026 MODE_O SHALL never equal 11.
REQ-027 MODE_O SHALL change only at a state change.
REQ-028 Start to DONE SHALL take (N_sg+4)*(SETTLE_CYC+1) cycles, where N_sg = number of SGIO trials (1..16).

Reset
REQ-029 RST_I=1 SHALL immediately force the following, including mid-calibration: IDLE, MODE_O=00, D_IOSG_O=0, D_LVDS_O=0, BUSY_O=0, DONE_O=0, ERR_O=00, counters and synchronizer cleared.
REQ-030 After RST_I deasserts, the block SHALL wait in IDLE for START_I.

Verification
REQ-031 Cell model with 200 ohm external (SGIO flips at n>=11, LVDS at code>=7), SETTLE_CYC=16, START pulse -> D_IOSG_O=15'h03FF, D_LVDS_O=6, ERR_O=00, DONE_O after 16*17=272 cycles.
REQ-032 RESULT_I[0] tied 1 -> one SGIO trial, ERR_O[0]=1, D_IOSG_O=0; RESULT_I[1] tied 0 -> D_LVDS_O=15, ERR_O[1]=1.
REQ-033 RESULT_I[0] tied 0 -> 16 SGIO trials, D_IOSG_O=15'h7FFF, ERR_O[0]=1; RESULT_I[1] tied 1 -> D_LVDS_O=0, ERR_O[1]=1.
REQ-034 RST_I pulse during LV_WAIT -> all outputs at reset values in the same cycle; START_I then begins a clean calibration from n=0.
REQ-035 START_I re-pulsed while BUSY_O=1 -> no restart, identical result and cycle count to REQ-031.
REQ-036 Monitor across all runs -> MODE_O never 11, and D_IOSG_O always a valid thermometer.

Source files
------------

// File: rtl/rtermcal_ctrl.sv
// rtermcal_ctrl -- termination-resistor calibration sequencer.
//
// Runs two searches against the RTERMCAL comparator cell:
//   1. SGIO: a linear thermometer sweep that raises the trim until the comparator
//      trips. The last code below the trip point is kept.
//   2. LVDS: a 4-bit successive-approximation search for the largest code whose
//      comparator output is still 0.
// Every trial code is held for SETTLE_CYC cycles and then evaluated in one
// further cycle. The comparator outputs are asynchronous, so they pass through a
// flop chain before they are evaluated.
//
// Ports
//   CLK_I      sole clock
//   RST_I      asynchronous, active-high reset
//   START_I    calibration request, honoured only in IDLE
//   RESULT_I   comparator outputs: [0] SGIO, [1] LVDS (asynchronous)
//   MODE_O     cell mode: 00 off, 01 SGIO compare, 10 LVDS compare
//   D_IOSG_O   thermometer trim [15:1] for the cell and the SGIO drivers
//   D_LVDS_O   binary trim for the cell and the LVDS drivers
//   BUSY_O     calibration in progress
//   DONE_O     one-cycle completion pulse
//   ERR_O      sticky out-of-range flags: [0] SGIO, [1] LVDS
module rtermcal_ctrl #(
  parameter int SETTLE_CYC  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        START_I,
  input  logic [1:0]  RESULT_I,
  output logic [1:0]  MODE_O,
  output logic [15:1] D_IOSG_O,
  output logic [3:0]  D_LVDS_O,
  output logic        BUSY_O,
  output logic        DONE_O,
  output logic [1:0]  ERR_O
);

  typedef enum logic [2:0] {
    IDLE, SG_WAIT, SG_EVAL, LV_WAIT, LV_EVAL, DONE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic [1:0] res_sync;
  logic [7:0] cnt;
  logic       settle_done;
  logic [3:0] sg_n;      // SGIO trial or final count; drives the thermometer
  logic [3:0] lv_code;
  logic [3:0] lv_next;
  logic [1:0] sar_bit;
  logic [1:0] err;

  // Synchronizer on the asynchronous comparator outputs.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= RESULT_I;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign res_sync = sync_q[SYNC_STAGES-1];

  // The settle count runs only in the WAIT states. It rolls over on the last
  // cycle of a WAIT, so each WAIT lasts exactly SETTLE_CYC cycles.
  assign settle_done = (cnt == 8'(SETTLE_CYC - 1));

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START_I) state_nxt = SG_WAIT;
      SG_WAIT: if (settle_done) state_nxt = SG_EVAL;
      SG_EVAL: state_nxt = (!res_sync[0] && sg_n != 4'd15) ? SG_WAIT : LV_WAIT;
      LV_WAIT: if (settle_done) state_nxt = LV_EVAL;
      LV_EVAL: state_nxt = (sar_bit != 2'd0) ? LV_WAIT : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SAR step: drop the bit under test if the comparator tripped, then try the
  // next lower bit.
  always_comb begin
    lv_next = lv_code;
    if (res_sync[1]) lv_next[sar_bit] = 1'b0;
    if (sar_bit != 2'd0) lv_next[sar_bit - 2'd1] = 1'b1;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      cnt     <= '0;
      sg_n    <= '0;
      lv_code <= '0;
      sar_bit <= '0;
      err     <= '0;
    end else begin
      if (state == SG_WAIT || state == LV_WAIT) cnt <= settle_done ? 8'd0 : cnt + 8'd1;
      else                                      cnt <= '0;

      case (state)
        IDLE: if (START_I) begin
          sg_n    <= '0;
          lv_code <= '0;
          sar_bit <= '0;
          err     <= '0;
        end
        SG_EVAL: begin
          if (!res_sync[0]) begin
            if (sg_n != 4'd15) sg_n <= sg_n + 4'd1;
            else               err[0] <= 1'b1;   // never tripped: stay at full scale
          end else begin
            if (sg_n == 4'd0) err[0] <= 1'b1;  // tripped at the first code
            else              sg_n <= sg_n - 4'd1;
          end
          // Set up the LVDS search in case the SGIO search finishes here.
          lv_code <= 4'b1000;
          sar_bit <= 2'd3;
        end
        LV_EVAL: begin
          lv_code <= lv_next;
          sar_bit <= sar_bit - 2'd1;
          if (sar_bit == 2'd0) err[1] <= (lv_next == 4'd0) || (lv_next == 4'd15);
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state only, so MODE_O changes only at a
  // state change and cannot take the value 11.
  always_comb begin
    MODE_O = 2'b00;
    if (state == SG_WAIT || state == SG_EVAL) MODE_O = 2'b01;
    if (state == LV_WAIT || state == LV_EVAL) MODE_O = 2'b10;
  end

  always_comb begin
    D_IOSG_O = '0;
    for (int i = 1; i <= 15; i++) D_IOSG_O[i] = (sg_n >= 4'(i));
  end

  assign D_LVDS_O = lv_code;
  assign BUSY_O   = (state != IDLE) && (state != DONE);
  assign DONE_O   = (state == DONE);
  assign ERR_O    = err;

endmodule

// File: tb/tb_rtermcal_ctrl.sv
// Directed bench for rtermcal_ctrl. A small cell model or a forced comparator
// pattern drives RESULT_I. Each test task checks its own expectations.
module tb_rtermcal_ctrl;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic        START_I = 1'b0;
  logic [1:0]  RESULT_I;
  logic [1:0]  MODE_O;
  logic [15:1] D_IOSG_O;
  logic [3:0]  D_LVDS_O;
  logic        BUSY_O, DONE_O;
  logic [1:0]  ERR_O;

  int checks = 0;
  int errors = 0;
  int tie_mode = 0;   // 0: 200-ohm cell model, 1: r0=1 r1=0, 2: r0=0 r1=1
  logic mon_en = 1'b0;

  rtermcal_ctrl #(.SETTLE_CYC(16), .SYNC_STAGES(2)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .START_I(START_I), .RESULT_I(RESULT_I),
    .MODE_O(MODE_O), .D_IOSG_O(D_IOSG_O), .D_LVDS_O(D_LVDS_O),
    .BUSY_O(BUSY_O), .DONE_O(DONE_O), .ERR_O(ERR_O)
  );

  always #5 CLK_I = ~CLK_I;

  always_comb begin
    case (tie_mode)
      1:       RESULT_I = 2'b01;
      2:       RESULT_I = 2'b10;
      default: RESULT_I = {(D_LVDS_O >= 4'd7), ($countones(D_IOSG_O) >= 11)};
    endcase
  end

  // Invariants: MODE_O never 11, D_IOSG_O always a thermometer from bit 1.
  always @(negedge CLK_I) begin
    if (mon_en) begin
      checks++;
      if (MODE_O === 2'b11 || ((D_IOSG_O & (D_IOSG_O + 15'd1)) !== 15'd0)) begin
        errors++;
        $display("FAIL monitor mode=%b iosg=%h", MODE_O, D_IOSG_O);
      end
    end
  end

  // Pulses START_I and counts cycles from the start edge until DONE_O.
  // Optionally re-pulses START_I mid-run. Returns -1 on timeout.
  task automatic run_cal(input int repulse_at, output int cyc);
    @(posedge CLK_I); #1 START_I = 1'b1;
    @(posedge CLK_I); #1 START_I = 1'b0;
    cyc = 0;
    while (DONE_O !== 1'b1 && cyc < 1000) begin
      if (cyc == repulse_at) START_I = 1'b1;
      @(posedge CLK_I); #1;
      START_I = 1'b0;
      cyc++;
    end
    if (DONE_O !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({MODE_O, D_IOSG_O, D_LVDS_O, BUSY_O, DONE_O, ERR_O} !== 25'd0) begin
      errors++;
      $display("FAIL reset_state got mode=%b iosg=%h lvds=%h busy=%b done=%b err=%b",
               MODE_O, D_IOSG_O, D_LVDS_O, BUSY_O, DONE_O, ERR_O);
    end
    repeat (3) @(posedge CLK_I);
    #1 RST_I = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(posedge CLK_I);
    #1;
    checks++;
    if (BUSY_O !== 1'b0 || MODE_O !== 2'b00) begin
      errors++;
      $display("FAIL idle_wait got busy=%b mode=%b want 0/00", BUSY_O, MODE_O);
    end
  endtask

  task automatic test_nominal;
    int cyc;
    tie_mode = 0;
    @(posedge CLK_I); #1 START_I = 1'b1;
    @(posedge CLK_I); #1 START_I = 1'b0;
    checks++;
    if (BUSY_O !== 1'b1 || MODE_O !== 2'b01 || D_IOSG_O !== 15'd0 || ERR_O !== 2'b00) begin
      errors++;
      $display("FAIL start_state got busy=%b mode=%b iosg=%h err=%b", BUSY_O, MODE_O, D_IOSG_O, ERR_O);
    end
    cyc = 0;
    while (DONE_O !== 1'b1 && cyc < 1000) begin
      @(posedge CLK_I); #1; cyc++;
    end
    checks++;
    if (cyc !== 272) begin errors++; $display("FAIL nominal_cycles got %0d want 272", cyc); end
    checks++;
    if (D_IOSG_O !== 15'h03FF || D_LVDS_O !== 4'd6 || ERR_O !== 2'b00) begin
      errors++;
      $display("FAIL nominal_codes got iosg=%h lvds=%0d err=%b want 03ff/6/00", D_IOSG_O, D_LVDS_O, ERR_O);
    end
    checks++;
    if (BUSY_O !== 1'b0 || MODE_O !== 2'b00) begin
      errors++;
      $display("FAIL done_state got busy=%b mode=%b want 0/00", BUSY_O, MODE_O);
    end
    @(posedge CLK_I); #1;
    checks++;
    if (DONE_O !== 1'b0) begin errors++; $display("FAIL done_pulse got done=%b want 0", DONE_O); end
    repeat (10) @(posedge CLK_I); #1;
    checks++;
    if (D_IOSG_O !== 15'h03FF || D_LVDS_O !== 4'd6 || ERR_O !== 2'b00 || BUSY_O !== 1'b0) begin
      errors++;
      $display("FAIL hold got iosg=%h lvds=%0d err=%b busy=%b", D_IOSG_O, D_LVDS_O, ERR_O, BUSY_O);
    end
  endtask

  task automatic test_low_rail;
    int cyc;
    tie_mode = 1;
    run_cal(-1, cyc);
    checks++;
    if (cyc !== 85) begin errors++; $display("FAIL low_rail_cycles got %0d want 85", cyc); end
    checks++;
    if (D_IOSG_O !== 15'd0 || D_LVDS_O !== 4'd15 || ERR_O !== 2'b11) begin
      errors++;
      $display("FAIL low_rail_codes got iosg=%h lvds=%0d err=%b want 0000/15/11", D_IOSG_O, D_LVDS_O, ERR_O);
    end
  endtask

  task automatic test_high_rail;
    int cyc;
    tie_mode = 2;
    run_cal(-1, cyc);
    checks++;
    if (cyc !== 340) begin errors++; $display("FAIL high_rail_cycles got %0d want 340", cyc); end
    checks++;
    if (D_IOSG_O !== 15'h7FFF || D_LVDS_O !== 4'd0 || ERR_O !== 2'b11) begin
      errors++;
      $display("FAIL high_rail_codes got iosg=%h lvds=%0d err=%b want 7fff/0/11", D_IOSG_O, D_LVDS_O, ERR_O);
    end
  endtask

  task automatic test_reset_mid_lv;
    int cyc;
    int n;
    tie_mode = 0;
    @(posedge CLK_I); #1 START_I = 1'b1;
    @(posedge CLK_I); #1 START_I = 1'b0;
    n = 0;
    while (MODE_O !== 2'b10 && n < 1000) begin @(posedge CLK_I); #1; n++; end
    checks++;
    if (MODE_O !== 2'b10) begin errors++; $display("FAIL reach_lv got mode=%b want 10", MODE_O); end
    repeat (3) @(posedge CLK_I);
    #2 RST_I = 1'b1;
    #1;
    checks++;
    if ({MODE_O, D_IOSG_O, D_LVDS_O, BUSY_O, DONE_O, ERR_O} !== 25'd0) begin
      errors++;
      $display("FAIL async_reset got mode=%b iosg=%h lvds=%h busy=%b done=%b err=%b",
               MODE_O, D_IOSG_O, D_LVDS_O, BUSY_O, DONE_O, ERR_O);
    end
    @(posedge CLK_I); #1 RST_I = 1'b0;
    run_cal(-1, cyc);
    checks++;
    if (cyc !== 272 || D_IOSG_O !== 15'h03FF || D_LVDS_O !== 4'd6 || ERR_O !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_cal got cyc=%0d iosg=%h lvds=%0d err=%b", cyc, D_IOSG_O, D_LVDS_O, ERR_O);
    end
  endtask

  task automatic test_restart_ignored;
    int cyc;
    tie_mode = 0;
    run_cal(150, cyc);
    checks++;
    if (cyc !== 272 || D_IOSG_O !== 15'h03FF || D_LVDS_O !== 4'd6 || ERR_O !== 2'b00) begin
      errors++;
      $display("FAIL restart_ignored got cyc=%0d iosg=%h lvds=%0d err=%b", cyc, D_IOSG_O, D_LVDS_O, ERR_O);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_low_rail();
    test_high_rail();
    test_reset_mid_lv();
    test_restart_ignored();
    repeat (2) @(posedge CLK_I);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
